// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN activation/pooling stages.
// relu_quant and max8 are reused by the other pooling and activation blocks.
package cnn_pkg;

    localparam int PIX_W = 8;
    localparam int SUM_W = 16;

    // ReLU, arithmetic right shift, then saturate to the positive int8 range.
    function automatic logic signed [PIX_W-1:0] relu_quant(
        input logic signed [SUM_W-1:0] sum,
        input logic        [3:0]       shift
    );
        logic signed [SUM_W-1:0] r;
        logic signed [SUM_W-1:0] s;
        r = sum[SUM_W-1] ? '0 : sum;
        s = r >>> shift;
        relu_quant = (s > 127) ? 8'sd127 : s[PIX_W-1:0];
    endfunction

    function automatic logic signed [PIX_W-1:0] max8(
        input logic signed [PIX_W-1:0] a,
        input logic signed [PIX_W-1:0] b
    );
        max8 = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_relu_maxpool_if.sv
// Stream bundle between the convolution adder stage and the pooling stage.
// master drives samples and clear; slave returns pooled pixels.
interface conv_relu_maxpool_if
    import cnn_pkg::*;
#(
    parameter int IMG_W = 26,
    parameter int IMG_H = 26
);
    localparam int PCW = $clog2(IMG_W / 2);
    localparam int PRW = $clog2(IMG_H / 2);

    logic                    clear;
    logic                    in_valid;
    logic signed [SUM_W-1:0] din;
    logic signed [PIX_W-1:0] pool_out;
    logic                    pool_valid;
    logic [PCW-1:0]          pool_col;
    logic [PRW-1:0]          pool_row;
    logic                    frame_done;

    modport master (
        output clear, in_valid, din,
        input  pool_out, pool_valid, pool_col, pool_row, frame_done
    );

    modport slave (
        input  clear, in_valid, din,
        output pool_out, pool_valid, pool_col, pool_row, frame_done
    );
endinterface

// File: rtl/pool_row_buffer.sv
// Half-width buffer of horizontal pair maxima from the even row.
// Synchronous write, combinational read at the same address; no reset needed.
module pool_row_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic signed [PIX_W-1:0] wdata_i,
    output logic signed [PIX_W-1:0] rdata_o
);
    logic signed [PIX_W-1:0] mem_q [DEPTH];

    // Store the even-row pair maximum for the odd row to pick up.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/conv_relu_maxpool.sv
// ReLU + requantise to int8, then 2x2 stride-2 max pooling over a raster stream.
// Horizontal pairs are folded in pair_q, vertical pairs via the row buffer.
module conv_relu_maxpool
    import cnn_pkg::*;
#(
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int SHIFT = 4
) (
    input logic          clk,
    input logic          rst_n,
    conv_relu_maxpool_if.slave bus
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int PCW = $clog2(IMG_W / 2);
    localparam int PRW = $clog2(IMG_H / 2);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_odd_dims
        $error("conv_relu_maxpool: IMG_W and IMG_H must be even");
    end
    if (SHIFT < 0 || SHIFT > 15) begin : g_bad_shift
        $error("conv_relu_maxpool: SHIFT must be 0..15");
    end

    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [PIX_W-1:0] pair_q, pair_d;
    logic signed [PIX_W-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic [PCW-1:0]          pcol_q, pcol_d;
    logic [PRW-1:0]          prow_q, prow_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    col_last;
    logic                    row_last;
    logic                    rb_we;
    logic [PCW-1:0]          addr;
    logic signed [PIX_W-1:0] qv;
    logic signed [PIX_W-1:0] hmax;
    logic signed [PIX_W-1:0] rb_rd;
    logic signed [PIX_W-1:0] wmax;

    assign accept   = bus.in_valid & ~bus.clear;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign addr     = PCW'(col_q >> 1);
    assign qv       = relu_quant(bus.din, 4'(SHIFT));
    assign hmax     = max8(pair_q, qv);
    assign wmax     = max8(rb_rd, hmax);
    assign rb_we    = accept & col_q[0] & ~row_q[0];

    pool_row_buffer #(
        .DEPTH (IMG_W / 2),
        .AW    (PCW)
    ) u_rowbuf (
        .clk     (clk),
        .we_i    (rb_we),
        .addr_i  (addr),
        .wdata_i (hmax),
        .rdata_o (rb_rd)
    );

    // Raster position tracking, pair folding and pooled output generation.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        out_d   = out_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (bus.clear) begin
            col_d  = '0;
            row_d  = '0;
            pair_d = '0;
            out_d  = '0;
            pcol_d = '0;
            prow_d = '0;
        end else if (accept) begin
            if (!col_q[0]) begin
                pair_d = qv;
            end else if (row_q[0]) begin
                out_d   = wmax;
                valid_d = 1'b1;
                pcol_d  = addr;
                prow_d  = PRW'(row_q >> 1);
                done_d  = col_last & row_last;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            pcol_q  <= '0;
            prow_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            done_q  <= done_d;
        end
    end

    assign bus.pool_out   = out_q;
    assign bus.pool_valid = valid_q;
    assign bus.pool_col   = pcol_q;
    assign bus.pool_row   = prow_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Directed bench for conv_relu_maxpool on 4x4 frames, SHIFT=0 and SHIFT=2.
// Expected pooled pixels come from a 2x2 window model pushed to a scoreboard.
module tb_conv_relu_maxpool;

    typedef struct {
        int out;
        int row;
        int col;
        int done;
        int due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   ndone0;
    bit   mon_en;
    int   fd [16];
    exp_t sq [2][$];

    conv_relu_maxpool_if #(.IMG_W(4), .IMG_H(4)) if0 ();
    conv_relu_maxpool_if #(.IMG_W(4), .IMG_H(4)) if2 ();

    conv_relu_maxpool #(.IMG_W(4), .IMG_H(4), .SHIFT(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    conv_relu_maxpool #(.IMG_W(4), .IMG_H(4), .SHIFT(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (if0.frame_done === 1'b1) ndone0++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qm(int d, int sh);
        int t;
        if (d < 0) return 0;
        t = d >>> sh;
        return (t > 127) ? 127 : t;
    endfunction

    function automatic int mx(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic mon(int s, logic v, logic [7:0] o,
                       logic [31:0] r, logic [31:0] c, logic d);
        exp_t e;
        bit   late;
        if (v === 1'b1) begin
            chk($sformatf("u%0d strobe expected", s),
                32'(sq[s].size() > 0), 32'd1);
            if (sq[s].size() > 0) begin
                e = sq[s].pop_front();
                chk($sformatf("u%0d out", s), 32'(o), 32'(e.out));
                chk($sformatf("u%0d row", s), r, 32'(e.row));
                chk($sformatf("u%0d col", s), c, 32'(e.col));
                chk($sformatf("u%0d frame_done", s), 32'(d), 32'(e.done));
                chk($sformatf("u%0d latency", s), 32'(cyc), 32'(e.due));
            end
        end else begin
            late = (sq[s].size() > 0) && (sq[s][0].due <= cyc);
            chk($sformatf("u%0d missing strobe", s), 32'(late), 32'd0);
            if (late) void'(sq[s].pop_front());
        end
        chk($sformatf("u%0d done without valid", s),
            32'(d === 1'b1 && v !== 1'b1), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, if0.pool_valid, if0.pool_out,
                32'(if0.pool_row), 32'(if0.pool_col), if0.frame_done);
            mon(1, if2.pool_valid, if2.pool_out,
                32'(if2.pool_row), 32'(if2.pool_col), if2.frame_done);
        end
    end

    task automatic drv(int s, bit v, bit clr, int d);
        @(posedge clk);
        #1;
        if0.in_valid = (s == 0) && v;
        if0.clear    = (s == 0) && clr;
        if0.din      = (s == 0) ? 16'(d) : 16'd0;
        if2.in_valid = (s == 1) && v;
        if2.clear    = (s == 1) && clr;
        if2.din      = (s == 1) ? 16'(d) : 16'd0;
    endtask

    task automatic idle(int n);
        repeat (n) drv(0, 1'b0, 1'b0, 0);
    endtask

    task automatic run(int s, int sh, int n, bit gap);
        exp_t e;
        int   r;
        int   c;
        for (int i = 0; i < n; i++) begin
            if (gap && $urandom_range(1) == 0) begin
                drv(s, 1'b0, 1'b0, int'($urandom_range(65535)));
            end
            drv(s, 1'b1, 1'b0, fd[i]);
            r = i / 4;
            c = i % 4;
            if ((r % 2) == 1 && (c % 2) == 1) begin
                e.out  = mx(mx(qm(fd[(r-1)*4 + c-1], sh), qm(fd[(r-1)*4 + c], sh)),
                            mx(qm(fd[r*4 + c-1], sh), qm(fd[r*4 + c], sh)));
                e.row  = r / 2;
                e.col  = c / 2;
                e.done = (i == 15) ? 1 : 0;
                e.due  = cyc + 1;
                sq[s].push_back(e);
            end
        end
    endtask

    task automatic basic_frame();
        for (int i = 0; i < 16; i++) fd[i] = i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        clk    = 1'b0;
        rst_n  = 1'b0;
        cyc    = 0;
        total  = 0;
        bad    = 0;
        ndone0 = 0;
        mon_en = 1'b0;
        if0.in_valid = 1'b0;
        if0.clear    = 1'b0;
        if0.din      = '0;
        if2.in_valid = 1'b0;
        if2.clear    = 1'b0;
        if2.din      = '0;
        #12;
        rst_n = 1'b1;

        chk("reset u0 pool_out", 32'(if0.pool_out), 32'd0);
        chk("reset u0 pool_valid", 32'(if0.pool_valid), 32'd0);
        chk("reset u0 frame_done", 32'(if0.frame_done), 32'd0);
        chk("reset u2 pool_out", 32'(if2.pool_out), 32'd0);
        chk("reset u2 pool_valid", 32'(if2.pool_valid), 32'd0);
        chk("reset u2 pool_col", 32'(if2.pool_col), 32'd0);
        mon_en = 1'b1;

        basic_frame();
        run(0, 0, 16, 1'b0);
        idle(3);
        chk("basic frame_done count", 32'(ndone0), 32'd1);

        for (int i = 0; i < 16; i++) fd[i] = -100;
        run(0, 0, 16, 1'b0);
        idle(3);

        for (int i = 0; i < 16; i++) fd[i] = 0;
        fd[0] = -32768;
        fd[1] = 3;
        fd[4] = 3;
        fd[5] = 3;
        run(0, 0, 16, 1'b0);
        idle(3);

        for (int i = 0; i < 16; i++) fd[i] = 0;
        fd[0] = 1000;
        fd[1] = 300;
        fd[4] = 8;
        fd[5] = -4;
        fd[2] = 300;
        fd[3] = 8;
        run(1, 2, 16, 1'b0);
        idle(3);

        basic_frame();
        run(0, 0, 16, 1'b1);
        idle(3);

        basic_frame();
        run(0, 0, 6, 1'b0);
        idle(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset pool_out", 32'(if0.pool_out), 32'd0);
        chk("async reset pool_valid", 32'(if0.pool_valid), 32'd0);
        chk("async reset pool_col", 32'(if0.pool_col), 32'd0);
        chk("async reset pool_row", 32'(if0.pool_row), 32'd0);
        chk("async reset frame_done", 32'(if0.frame_done), 32'd0);
        #1;
        rst_n = 1'b1;
        run(0, 0, 16, 1'b0);
        idle(3);

        run(0, 0, 3, 1'b0);
        drv(0, 1'b1, 1'b1, 99);
        idle(1);
        chk("clear pool_out", 32'(if0.pool_out), 32'd0);
        chk("clear pool_valid", 32'(if0.pool_valid), 32'd0);
        nd = ndone0;
        run(0, 0, 16, 1'b0);
        run(0, 0, 16, 1'b0);
        idle(3);
        chk("back-to-back frame_done count", 32'(ndone0 - nd), 32'd2);

        chk("u0 scoreboard drained", 32'(sq[0].size()), 32'd0);
        chk("u2 scoreboard drained", 32'(sq[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_relu_maxpool.md
Name: conv_relu_maxpool

Overview:
- Downstream consumer of the 3x3 convolution/adder stage.
- Takes the raster-ordered stream of signed 16-bit convolution sums for one feature map.
- Applies ReLU, arithmetic right-shift requantisation and saturation to signed 8-bit.
- Performs 2x2 stride-2 max pooling using a half-width row buffer, and emits pooled 8-bit pixels plus their coordinates to feed the next convolution layer's 8-bit inputs.

Parameters:
- IMG_W, 26, convolution output width in pixels; must be even, elaboration error otherwise.
- IMG_H, 26, convolution output height in rows; must be even, elaboration error otherwise.
- SHIFT, 4, arithmetic right shift applied after ReLU; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame realign; zeroes counters and outputs.
- in_valid  input  1  one-cycle strobe per convolution result.
- din  input  16  signed convolution sum.
- pool_out  output  8  signed pooled pixel, range 0..127.
- pool_valid  output  1  one-cycle strobe, pool_out valid.
- pool_col  output  $clog2(IMG_W/2)  pooled column index of pool_out.
- pool_row  output  $clog2(IMG_H/2)  pooled row index of pool_out.
- frame_done  output  1  one-cycle pulse coincident with the last pool_valid of a frame.

Behaviour:
- Reset (rst_n low, async): col, row, pair_reg, pool_out, pool_valid, pool_col, pool_row and frame_done all go to 0. Row buffer contents are not reset; they need no reset because every odd-row read uses an entry written in the preceding even row.
- Quantise, applied per accepted sample:
  - r = (din < 0) ? 0 : din.
  - s = r >>> SHIFT.
  - q = (s > 127) ? 127 : s[7:0].
  - Max is monotonic, so quantising before pooling is exact.
- Sample accepted when in_valid=1 and clear=0. Otherwise col, row, pair_reg and the buffer hold, and pool_valid and frame_done are 0 that cycle.
- Accepted sample at (row, col):
  - col even: pair_reg <= q.
  - col odd: h = max(pair_reg, q).
    - row even: rowbuf[col>>1] <= h.
    - row odd: pool_out <= max(rowbuf[col>>1], h); pool_valid <= 1; pool_col <= col>>1; pool_row <= row>>1.
  - col advances; at IMG_W-1 it wraps to 0 and row advances. At IMG_H-1 with col IMG_W-1, row wraps to 0.
- Latency: pool_valid is asserted the cycle after the sample completing the 2x2 window (odd row, odd col).
- frame_done <= 1 together with pool_valid when the completing sample is at (IMG_H-1, IMG_W-1).
- pool_out, pool_col and pool_row hold their last values between strobes.
- Back-to-back frames are supported with no bubble; in_valid may be asserted every cycle.
- clear=1: synchronous, same reset values as rst_n. It wins over a simultaneous in_valid, and that sample is dropped.
- rst_n mid-frame: partial frame discarded; the next accepted sample is treated as (0,0).
- Comparisons are signed 8-bit; all values are 0..127 after ReLU and saturation.

Decomposition:
- Shared package cnn_pkg holds:
  - PIX_W=8 and SUM_W=16.
  - Function relu_quant(sum, shift) returning the saturated 8-bit value.
  - Function max8.
  - Both functions are reused by other pooling and activation stages.
- One sub-module, pool_row_buffer: IMG_W/2 entries x 8 bits, one synchronous write port, one combinational read port, same address (col>>1). Maps to distributed RAM.

Test Plan:
- Basic pooling. IMG_W=IMG_H=4, SHIFT=0, din=r*4+c streamed every cycle.
  - Required: pool_valid 4 times with (row,col,out) = (0,0,5), (0,1,7), (1,0,13), (1,1,15).
  - Each strobe is one cycle after samples 5, 7, 13 and 15 respectively.
  - frame_done only with out=15.
- ReLU. All 16 samples din=-100.
  - Required: four outputs, all 0.
  - Mix test: din=-32768 at (0,0) and din=3 elsewhere in that window gives out=3.
- Saturation and shift. SHIFT=2.
  - Window {1000, 300, 8, -4} gives out=127 (1000>>>2=250, saturated).
  - Window {300, 8, 0, 0} gives out=75.
- Gapped input. Same stream as the basic pooling test with in_valid pseudo-randomly low on about 50% of cycles.
  - Required: identical out/coordinate sequence; no pool_valid on idle cycles.
- Reset mid-frame. Pulse rst_n low after 6 accepted samples.
  - Required: all outputs 0 immediately, asynchronously.
  - The following full frame reproduces the basic pooling test results exactly.
- clear collision and back-to-back frames.
  - clear=1 with in_valid=1 and din=99 on sample 3: din=99 is dropped and counters return to 0.
  - Then two consecutive basic-pooling frames with no gap: 8 outputs, 5, 7, 13, 15 each time, and two frame_done pulses.
